gpio_button_conditioner: RTL and testbench

- Input conditioning stage that sits directly upstream of the GPIO example system's `buttons` input.
- Synchronises raw, asynchronous push-button pins into sys_clk and debounces each channel independently.
- Produces clean levels, single-cycle press/release pulses, and a valid/ready event record. The AXI-Lite GPIO path consumes the clean levels; a status/IRQ consumer drains the events.

---
 rtl/gpio_button_conditioner.sv | 139 +++++++++++++
 tb/tb_gpio_button_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_button_conditioner.sv
// Push-button front end: per-channel synchroniser, debouncer, edge pulses and a valid/ready event record.
// Optional build macro BTN_AUTO_REPEAT_EN adds per-channel hold timers that re-fire press pulses.
module gpio_button_conditioner #(
  parameter int NUM_BUTTONS     = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic                     sys_clk,
  input  logic                     sys_reset,
  input  logic [NUM_BUTTONS-1:0]   buttons_raw,
  output logic [NUM_BUTTONS-1:0]   buttons_clean,
  output logic [NUM_BUTTONS-1:0]   press_pulse,
  output logic [NUM_BUTTONS-1:0]   release_pulse,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic [2*NUM_BUTTONS-1:0] event_data,
  output logic                     event_overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0]   clean_reg;
  logic [NUM_BUTTONS-1:0]   press_reg;
  logic [NUM_BUTTONS-1:0]   release_reg;
  logic [NUM_BUTTONS-1:0]   sync_out;
  logic [NUM_BUTTONS-1:0]   toggle;
  logic [NUM_BUTTONS-1:0]   rep_fire;
  logic [NUM_BUTTONS-1:0]   clean_next;
  logic [NUM_BUTTONS-1:0]   press_next;
  logic [NUM_BUTTONS-1:0]   release_next;
  logic [2*NUM_BUTTONS-1:0] pending_reg;
  logic [2*NUM_BUTTONS-1:0] pending_next;
  logic [2*NUM_BUTTONS-1:0] new_ev;
  logic                     valid_reg;
  logic                     overflow_reg;
  logic                     overflow_next;
  logic                     handshake;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CW-1:0]          cnt_reg;

      always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) sync_reg <= '0;
        else           sync_reg <= {sync_reg[SYNC_STAGES-2:0], buttons_raw[gi]};
      end

      assign sync_out[gi] = sync_reg[SYNC_STAGES-1];
      // Only an unbroken run of disagreement reaching the last count flips the level.
      assign toggle[gi] = (sync_out[gi] != clean_reg[gi]) && (cnt_reg == CNT_LAST);

      always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset)                          cnt_reg <= '0;
        else if (sync_out[gi] == clean_reg[gi]) cnt_reg <= '0;
        else if (cnt_reg == CNT_LAST)           cnt_reg <= '0;
        else                                    cnt_reg <= cnt_reg + 1'b1;
      end

`ifdef BTN_AUTO_REPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = $clog2(RMAX + 1);
      logic [RW-1:0] rep_cnt_reg;
      logic          rep_phase_reg;
      logic          hold;
      logic [RW-1:0] rep_limit;

      // Timer runs only while the clean level stays high and is not about to fall.
      assign hold      = clean_reg[gi] && !toggle[gi];
      assign rep_limit = rep_phase_reg ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
      assign rep_fire[gi] = hold && (rep_cnt_reg == rep_limit);

      always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
          rep_cnt_reg   <= '0;
          rep_phase_reg <= 1'b0;
        end else if (!hold) begin
          rep_cnt_reg   <= '0;
          rep_phase_reg <= 1'b0;
        end else if (rep_fire[gi]) begin
          rep_cnt_reg   <= '0;
          rep_phase_reg <= 1'b1;
        end else begin
          rep_cnt_reg   <= rep_cnt_reg + 1'b1;
        end
      end
`else
      assign rep_fire[gi] = 1'b0;
`endif
    end
  endgenerate

  assign clean_next   = clean_reg ^ toggle;
  assign press_next   = (toggle & ~clean_reg) | rep_fire;
  assign release_next = toggle & clean_reg;
  assign new_ev       = {release_next, press_next};
  assign handshake    = valid_reg && event_ready;

  // A drained record is replaced by this cycle's events so nothing arriving now is lost.
  always_comb begin
    pending_next  = pending_reg | new_ev;
    overflow_next = 1'b0;
    if (handshake) begin
      pending_next = new_ev;
    end else begin
      overflow_next = |(pending_reg & new_ev);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      clean_reg    <= '0;
      press_reg    <= '0;
      release_reg  <= '0;
      pending_reg  <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      clean_reg    <= clean_next;
      press_reg    <= press_next;
      release_reg  <= release_next;
      pending_reg  <= pending_next;
      valid_reg    <= |pending_next;
      overflow_reg <= overflow_next;
    end
  end

  assign buttons_clean  = clean_reg;
  assign press_pulse    = press_reg;
  assign release_pulse  = release_reg;
  assign event_valid    = valid_reg;
  assign event_data     = pending_reg;
  assign event_overflow = overflow_reg;

endmodule

// File: tb/tb_gpio_button_conditioner.sv
// Directed bench for gpio_button_conditioner (4 channels, 2 sync stages, 8-cycle debounce).
// Auto-repeat expectations follow BTN_AUTO_REPEAT_EN when the bench is built with it.
module tb_gpio_button_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] clean;
  logic [3:0] press;
  logic [3:0] rel;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  gpio_button_conditioner #(
    .NUM_BUTTONS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(40), .REPEAT_PERIOD(16)
  ) dut (
    .sys_clk(clk), .sys_reset(rst), .buttons_raw(raw),
    .buttons_clean(clean), .press_pulse(press), .release_pulse(rel),
    .event_valid(valid), .event_ready(ready), .event_data(data),
    .event_overflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drain();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  initial begin
    int   npress;
    logic seen;
    logic exp_rep;

    // Reset with all pins pressed
    rst = 1'b1; raw = 4'hF; ready = 1'b0;
    tick(3);
    check("rst_outputs", {clean, press, rel, valid, data, ovf}, 32'h0);
    rst = 1'b0;
    tick(9);
    check("rst_clean_pre", clean, 4'h0);
    tick(1);
    check("rst_clean_post", clean, 4'hF);
    check("rst_press", press, 4'hF);
    check("rst_data", data, 8'h0F);
    tick(1);
    check("rst_press_end", press, 4'h0);
    drain();
    raw = 4'h0;
    tick(10);
    check("rel_all_pulse", rel, 4'hF);
    check("rel_all_data", data, 8'hF0);
    drain();
    check("rel_all_drained", valid, 1'b0);

    // Single press on channel 0
    raw[0] = 1'b1;
    tick(9);
    check("b0_clean_pre", clean, 4'h0);
    tick(1);
    check("b0_clean", clean, 4'h1);
    check("b0_press", press, 4'h1);
    check("b0_valid", valid, 1'b1);
    check("b0_data", data, 8'h01);
    tick(1);
    check("b0_press_end", press, 4'h0);
    drain();
    check("b0_drained", valid, 1'b0);
    raw[0] = 1'b0;
    tick(10);
    check("b0_release", rel, 4'h1);
    drain();

    // Glitch shorter than the debounce window
    seen = 1'b0;
    raw[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      seen = seen | (|clean) | (|press) | valid;
    end
    raw[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | (|clean) | (|press) | valid;
    end
    check("glitch_quiet", seen, 1'b0);

    // Bounce on channel 3, then stable high
    npress = 0;
    for (int i = 0; i < 24; i++) begin
      raw[3] = ((i / 3) % 2) == 0;
      tick(1);
      if (press[3]) npress++;
    end
    raw[3] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (press[3]) npress++;
    end
    check("bounce_early", npress, 0);
    tick(1);
    check("bounce_clean", clean, 4'h8);
    check("bounce_press", press, 4'h8);
    check("bounce_data", data, 8'h08);
    for (int i = 0; i < 15; i++) begin
      if (press[3]) npress++;
      tick(1);
    end
    check("bounce_once", npress, 1);
    drain();
    raw[3] = 1'b0;
    tick(10);
    check("b3_release", rel, 4'h8);
    drain();

    // Hold off the consumer, accumulate, then overflow
    raw[2] = 1'b1;
    tick(10);
    check("b2_press_data", data, 8'h04);
    raw[2] = 1'b0;
    tick(10);
    check("b2_pr_data", data, 8'h44);
    tick(5);
    check("b2_hold_data", data, 8'h44);
    check("b2_hold_valid", valid, 1'b1);
    raw[2] = 1'b1;
    tick(9);
    check("ovf_pre", ovf, 1'b0);
    tick(1);
    check("ovf_pulse", ovf, 1'b1);
    check("ovf_data", data, 8'h44);
    tick(1);
    check("ovf_end", ovf, 1'b0);
    raw[1] = 1'b1;
    tick(9);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("hs_same_cycle_data", data, 8'h02);
    check("hs_same_cycle_valid", valid, 1'b1);
    drain();
    raw[1] = 1'b0; raw[2] = 1'b0;
    tick(12);
    drain();

    // Long hold on channel 0: repeats only with the auto-repeat build
    ready = 1'b1;
    raw[0] = 1'b1;
    tick(10);
    check("hold_first_press", press, 4'h1);
    npress = 0;
    for (int t = 1; t <= 125; t++) begin
      if (t == 101) raw[0] = 1'b0;
      tick(1);
`ifdef BTN_AUTO_REPEAT_EN
      exp_rep = (t == 40) || (t == 56) || (t == 72) || (t == 88) || (t == 104);
`else
      exp_rep = 1'b0;
`endif
      if (press[0] !== exp_rep) npress++;
    end
    check("hold_repeat_pattern", npress, 0);
    check("hold_released", clean, 4'h0);
    ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
